// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP slice multiplier path.
//
// Contents:
//   - operand / product width constants (A_W, B_W, M_W, PP_SPLIT)
//   - MREG pipeline-depth encodings
//   - width helpers for the split partial-product form
//   - smul(): full-width signed product used by the 0/1-stage paths
package dsp_pkg;

    // Operand and product widths of the slice multiplier.
    localparam int A_W      = 18;
    localparam int B_W      = 18;
    localparam int M_W      = 36;

    // Bit position where B is split for the two-stage partial-product form.
    localparam int PP_SPLIT = 9;

    // Pipeline depth encodings for the MREG parameter.
    localparam int MREG_COMB = 0;
    localparam int MREG_ONE  = 1;
    localparam int MREG_TWO  = 2;

    // Low partial product: signed A times zero-extended B[split-1:0].
    // The extra bit holds the zero sign bit of the unsigned low slice.
    function automatic int pl_width(input int split);
        return A_W + split + 1;
    endfunction

    // High partial product: signed A times signed B[B_W-1:split].
    function automatic int ph_width(input int split);
        return A_W + B_W - split;
    endfunction

    // Full two's-complement product, sign-extended to M_W bits.
    // Both operands are widened first so the multiply runs at M_W bits;
    // the true product always fits (worst case 2^34), so nothing is lost.
    function automatic logic [M_W-1:0] smul(input logic [A_W-1:0] a,
                                            input logic [B_W-1:0] b);
        logic signed [M_W-1:0] ae;
        logic signed [M_W-1:0] be;
        ae = M_W'($signed(a));
        be = M_W'($signed(b));
        return ae * be;
    endfunction

endpackage

// File: rtl/mult_pp.sv
// Split partial-product generator for the two-stage multiplier pipeline.
//
// B is cut at bit SPLIT into an unsigned low slice and a signed high slice:
//   B = sext(B[B_W-1:SPLIT]) * 2^SPLIT + zext(B[SPLIT-1:0])
// so A*B = (PH << SPLIT) + PL with
//   PL = A * zext(B[SPLIT-1:0])   (PL_W bits, signed)
//   PH = A * sext(B[B_W-1:SPLIT]) (PH_W bits, signed)
//
// Purely combinational.
//
// Ports:
//   a_i   in   A_W   signed multiplicand
//   b_i   in   B_W   signed multiplier
//   pl_o  out  PL_W  low partial product
//   ph_o  out  PH_W  high partial product
module mult_pp
    import dsp_pkg::*;
#(
    parameter int SPLIT = PP_SPLIT
) (
    input  logic [A_W-1:0]             a_i,
    input  logic [B_W-1:0]             b_i,
    output logic [pl_width(SPLIT)-1:0] pl_o,
    output logic [ph_width(SPLIT)-1:0] ph_o
);

    localparam int PL_W = pl_width(SPLIT);
    localparam int PH_W = ph_width(SPLIT);
    localparam int BH_W = B_W - SPLIT;

    logic signed [PL_W-1:0] a_lo;
    logic signed [PL_W-1:0] b_lo;
    logic signed [PH_W-1:0] a_hi;
    logic signed [PH_W-1:0] b_hi;
    logic signed [BH_W-1:0] b_hi_slice;

    always_comb begin
        // Low slice is unsigned: zero-extend so its top bit is not
        // mistaken for a sign bit.
        a_lo       = PL_W'($signed(a_i));
        b_lo       = {{(PL_W - SPLIT){1'b0}}, b_i[SPLIT-1:0]};

        // High slice carries the sign of B.
        b_hi_slice = b_i[B_W-1:SPLIT];
        a_hi       = PH_W'($signed(a_i));
        b_hi       = PH_W'(b_hi_slice);

        pl_o       = a_lo * b_lo;
        ph_o       = a_hi * b_hi;
    end

endmodule

// File: rtl/m_reg_stage.sv
// Multiplier stage following the B1 register stage of the DSP slice.
//
// Forms the signed A1*B1 product and passes it through MREG pipeline
// registers (0, 1 or 2), tracking a valid flag alongside the data.
//   MREG=0 : product is combinational on M_mux, QM tied to zero.
//   MREG=1 : single product register.
//   MREG=2 : partial-product register (PL/PH) then product register;
//            bit-identical to MREG=1, one cycle later.
// CEM gates every register including the valid pipe; RSTM clears all
// registers asynchronously. The valid flag never gates data.
//
// Ports:
//   CLK       in   1    slice clock, rising edge
//   RSTM      in   1    async active-low reset
//   CEM       in   1    clock enable for all stage registers
//   A1        in   18   signed multiplicand
//   B1        in   18   signed multiplier
//   VALID_IN  in   1    qualifies A1/B1 this cycle
//   QM        out  36   final product register (0 when MREG=0)
//   M_mux     out  36   selected product
//   VALID_OUT out  1    qualifies M_mux
module m_reg_stage
    import dsp_pkg::*;
#(
    parameter int MREG  = MREG_ONE,
    parameter int SPLIT = PP_SPLIT
) (
    input  logic           CLK,
    input  logic           RSTM,
    input  logic           CEM,
    input  logic [A_W-1:0] A1,
    input  logic [B_W-1:0] B1,
    input  logic           VALID_IN,
    output logic [M_W-1:0] QM,
    output logic [M_W-1:0] M_mux,
    output logic           VALID_OUT
);

    // vld_pipe[0] is the incoming flag; [MREG:1] are registered stages.
    logic [MREG:0] vld_pipe;

    assign vld_pipe[0] = VALID_IN;
    assign VALID_OUT   = vld_pipe[MREG];

    generate
        if (MREG == MREG_COMB) begin : g_comb
            // No storage at all: clock, reset and enable are unused here.
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, CLK, RSTM, CEM};

            assign M_mux = smul(A1, B1);
            assign QM    = '0;

        end else if (MREG == MREG_ONE) begin : g_one
            logic [M_W-1:0] qm_d;
            logic [M_W-1:0] qm_q;
            logic           vld_q;

            assign qm_d = smul(A1, B1);

            always_ff @(posedge CLK or negedge RSTM) begin
                if (!RSTM) begin
                    qm_q  <= '0;
                    vld_q <= 1'b0;
                end else if (CEM) begin
                    qm_q  <= qm_d;
                    vld_q <= vld_pipe[0];
                end
            end

            assign vld_pipe[1] = vld_q;
            assign QM          = qm_q;
            assign M_mux       = qm_q;

        end else begin : g_two
            localparam int PL_W = pl_width(SPLIT);
            localparam int PH_W = ph_width(SPLIT);

            logic [PL_W-1:0] pl_d;
            logic [PL_W-1:0] pl_q;
            logic [PH_W-1:0] ph_d;
            logic [PH_W-1:0] ph_q;
            logic [M_W-1:0]  ph_ext;
            logic [M_W-1:0]  pl_ext;
            logic [M_W-1:0]  qm_d;
            logic [M_W-1:0]  qm_q;
            logic [2:1]      vld_q;

            mult_pp #(
                .SPLIT (SPLIT)
            ) u_pp (
                .a_i  (A1),
                .b_i  (B1),
                .pl_o (pl_d),
                .ph_o (ph_d)
            );

            // Recombine registered partials. Both are signed, so each is
            // sign-extended before the weighted add; the sum wraps at M_W
            // bits, which is exact because the true product fits.
            always_comb begin
                ph_ext = {{(M_W - PH_W){ph_q[PH_W-1]}}, ph_q};
                pl_ext = {{(M_W - PL_W){pl_q[PL_W-1]}}, pl_q};
                qm_d   = (ph_ext << SPLIT) + pl_ext;
            end

            always_ff @(posedge CLK or negedge RSTM) begin
                if (!RSTM) begin
                    pl_q  <= '0;
                    ph_q  <= '0;
                    qm_q  <= '0;
                    vld_q <= '0;
                end else if (CEM) begin
                    pl_q  <= pl_d;
                    ph_q  <= ph_d;
                    qm_q  <= qm_d;
                    vld_q <= vld_pipe[1:0];
                end
            end

            assign vld_pipe[2:1] = vld_q;
            assign QM            = qm_q;
            assign M_mux         = qm_q;
        end
    endgenerate

endmodule
